// File: rtl/lamp_pkg.sv
// Shared widths and constants for the lamp PWM fader.
package lamp_pkg;
  localparam int BRIGHT_W = 5;
  localparam int BRIGHT_MAX = 31;
  localparam int PWM_PERIOD = 31;
  localparam int NUM_LAMPS_DEF = 6;

  typedef logic [BRIGHT_W-1:0] bright_t;
endpackage

// File: rtl/lamp_channel.sv
// One lamp channel: brightness register, step toward target, PWM compare.
// Ramping only when LAMP_FADE_EN is defined; otherwise target loads directly.
module lamp_channel
  import lamp_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    tick,
  input  logic    on,
  input  bright_t pwm_cnt,
  output logic    lamp_out,
  output bright_t bright,
  output logic    differ,
  output logic    dark
);

  bright_t target;
  bright_t nxt;

`ifdef LAMP_FADE_EN
  always_comb begin
    target = on ? bright_t'(BRIGHT_MAX) : '0;
    nxt = bright;
    if (tick) begin
      if (bright < target)
        nxt = bright + bright_t'(1);
      else if (bright > target)
        nxt = bright - bright_t'(1);
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;

  always_comb begin
    target = on ? bright_t'(BRIGHT_MAX) : '0;
    nxt = target;
  end
`endif

  // flags describe the value being written, so they line up with bright
  assign differ = (nxt != target);
  assign dark = (nxt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright <= '0;
      lamp_out <= 1'b0;
    end else begin
      bright <= nxt;
      lamp_out <= (bright > pwm_cnt);
    end
  end

endmodule

// File: rtl/lamp_pwm_fader.sv
// Multi-channel lamp PWM fader with shared prescaler and PWM counter.
// Fading is enabled by defining LAMP_FADE_EN; default build snaps to target.
module lamp_pwm_fader
  import lamp_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int NUM_LAMPS = NUM_LAMPS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LAMPS-1:0] room_light,
  output logic [NUM_LAMPS-1:0] lamp_out,
  output logic                 busy,
  output logic                 all_dark
);

  logic tick;
  bright_t pwm_cnt;
  logic [NUM_LAMPS-1:0] differ;
  logic [NUM_LAMPS-1:0] dark;

`ifdef LAMP_FADE_EN
  logic [15:0] presc;

  assign tick = (presc == 16'(STEP_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc <= '0;
    else if (tick)
      presc <= '0;
    else
      presc <= presc + 16'd1;
  end
`else
  localparam int unused_div = STEP_DIV;
  assign tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pwm_cnt <= '0;
    else if (pwm_cnt == bright_t'(PWM_PERIOD - 1))
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + bright_t'(1);
  end

  for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_ch
    bright_t bright;

    lamp_channel u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .on       (room_light[i]),
      .pwm_cnt  (pwm_cnt),
      .lamp_out (lamp_out[i]),
      .bright   (bright),
      .differ   (differ[i]),
      .dark     (dark[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      all_dark <= 1'b1;
    end else begin
      busy <= |differ;
      all_dark <= &dark;
    end
  end

endmodule
